// File: rtl/fir_pkg.sv
// Shared FIR datapath widths and the shift/clip helper used by the output requantizer.
package fir_pkg;

  localparam int DATA_IN_WIDTH_DEF  = 64;
  localparam int DATA_OUT_WIDTH_DEF = 16;

  // Helper operates on the rounded (one bit wider) accumulator and the default output width.
  localparam int REQ_IN_W  = DATA_IN_WIDTH_DEF + 1;
  localparam int REQ_OUT_W = DATA_OUT_WIDTH_DEF;

  localparam int SAT_CNT_WIDTH = 16;
  localparam int OVF_FLAG_WIDTH = 1;
  localparam int SAT_FLAG_WIDTH = 1;

  typedef struct packed {
    logic                        sat;
    logic signed [REQ_OUT_W-1:0] sample;
  } requant_t;

  // Arithmetic shift then clip to a signed out_w-bit range.
  function automatic requant_t requant_sat(input logic signed [REQ_IN_W-1:0] r,
                                           input int shift,
                                           input int out_w);
    logic signed [REQ_IN_W-1:0] q;
    logic signed [REQ_IN_W-1:0] hi;
    logic signed [REQ_IN_W-1:0] lo;
    logic        [REQ_IN_W-1:0] one;
    requant_t                   res;
    one = REQ_IN_W'(1);
    q   = r >>> shift;
    hi  = $signed((one << (out_w - 1)) - one);
    lo  = ~hi;
    res.sat    = 1'b0;
    res.sample = q[REQ_OUT_W-1:0];
    if (q > hi) begin
      res.sat    = 1'b1;
      res.sample = hi[REQ_OUT_W-1:0];
    end else if (q < lo) begin
      res.sat    = 1'b1;
      res.sample = lo[REQ_OUT_W-1:0];
    end
    return res;
  endfunction

endpackage

// File: rtl/fir_requant_fifo.sv
// Small synchronous FIFO with a registered head word; head holds its last value when drained.
module fir_requant_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_inc;
  logic [CNT_W-1:0] count_reg;
  logic [WIDTH-1:0] head_reg;
  logic [WIDTH-1:0] head_next;
  logic             pop_ok;
  logic             push_ok;

  assign full      = (count_reg == CNT_W'(DEPTH));
  assign empty     = (count_reg == '0);
  assign pop_ok    = pop & ~empty;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push_ok   = push & (~full | pop_ok);
  assign rd_ptr_inc = rd_ptr_reg + PTR_W'(1);
  assign head_data = head_reg;

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  always_comb begin
    head_next = head_reg;
    if (pop_ok) begin
      if (count_reg > CNT_W'(1)) begin
        head_next = mem[rd_ptr_inc];
      end else if (push_ok) begin
        head_next = push_data;
      end
    end else if (push_ok && empty) begin
      head_next = push_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
      head_reg   <= '0;
    end else begin
      head_reg <= head_next;
      if (pop_ok) begin
        rd_ptr_reg <= rd_ptr_inc;
      end
      if (push_ok) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/fir_out_requant.sv
// FIR output requantizer: round, shift, saturate, then buffer behind a valid/ready FIFO.
// Optional saturating clip counter on sat_count when FIR_REQUANT_SAT_CNT_EN is defined.
module fir_out_requant
  import fir_pkg::*;
#(
  parameter int DATA_IN_WIDTH  = DATA_IN_WIDTH_DEF,
  parameter int DATA_OUT_WIDTH = DATA_OUT_WIDTH_DEF,
  parameter int SHIFT          = 31,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic                             in_valid,
  input  logic signed [DATA_IN_WIDTH-1:0]  data_in,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic signed [DATA_OUT_WIDTH-1:0] data_out,
  output logic                             sat_flag,
  output logic                             ovf_flag,
  input  logic                             flag_clear
`ifdef FIR_REQUANT_SAT_CNT_EN
  ,
  output logic [SAT_CNT_WIDTH-1:0]         sat_count
`endif
);

  localparam logic [DATA_IN_WIDTH:0] ROUND_INC = (DATA_IN_WIDTH+1)'(1) << (SHIFT - 1);

  logic                             v1_reg;
  logic signed [DATA_IN_WIDTH:0]    r_reg;
  logic signed [DATA_IN_WIDTH:0]    r_next;
  logic                             v2_reg;
  logic                             sat2_reg;
  logic signed [DATA_OUT_WIDTH-1:0] d2_reg;
  requant_t                         s2_res;
  logic                             fifo_full;
  logic                             fifo_empty;
  logic [DATA_OUT_WIDTH-1:0]        fifo_head;
  logic                             sat_evt;
  logic                             ovf_evt;
  logic                             sat_flag_reg;
  logic                             ovf_flag_reg;

  // One extra bit so the rounding increment never wraps the largest accumulator value.
  assign r_next = $signed({data_in[DATA_IN_WIDTH-1], data_in}) + $signed(ROUND_INC);
  assign s2_res = requant_sat(REQ_IN_W'(r_reg), SHIFT, DATA_OUT_WIDTH);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v1_reg   <= 1'b0;
      r_reg    <= '0;
      v2_reg   <= 1'b0;
      sat2_reg <= 1'b0;
      d2_reg   <= '0;
    end else begin
      v1_reg   <= in_valid;
      r_reg    <= r_next;
      v2_reg   <= v1_reg;
      sat2_reg <= v1_reg & s2_res.sat;
      d2_reg   <= s2_res.sample[DATA_OUT_WIDTH-1:0];
    end
  end

  fir_requant_fifo #(
    .WIDTH (DATA_OUT_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (v2_reg),
    .push_data (d2_reg),
    .pop       (out_ready),
    .head_data (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign out_valid = ~fifo_empty;
  assign data_out  = $signed(fifo_head);

  assign sat_evt = v2_reg & sat2_reg;
  // Full implies non-empty, so a ready consumer always frees a slot this cycle.
  assign ovf_evt = v2_reg & fifo_full & ~out_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sat_flag_reg <= 1'b0;
      ovf_flag_reg <= 1'b0;
    end else begin
      if (sat_evt) begin
        sat_flag_reg <= 1'b1;
      end else if (flag_clear) begin
        sat_flag_reg <= 1'b0;
      end
      if (ovf_evt) begin
        ovf_flag_reg <= 1'b1;
      end else if (flag_clear) begin
        ovf_flag_reg <= 1'b0;
      end
    end
  end

  assign sat_flag = sat_flag_reg;
  assign ovf_flag = ovf_flag_reg;

`ifdef FIR_REQUANT_SAT_CNT_EN
  logic [SAT_CNT_WIDTH-1:0] sat_cnt_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sat_cnt_reg <= '0;
    end else if (flag_clear) begin
      sat_cnt_reg <= sat_evt ? SAT_CNT_WIDTH'(1) : '0;
    end else if (sat_evt && (sat_cnt_reg != '1)) begin
      sat_cnt_reg <= sat_cnt_reg + SAT_CNT_WIDTH'(1);
    end
  end

  assign sat_count = sat_cnt_reg;
`endif

endmodule

// File: tb/tb_fir_out_requant.sv
// Directed bench for fir_out_requant: vector table plus FIFO full/drop/reset sequences.
module tb_fir_out_requant;

  logic               clk;
  logic               reset_n;
  logic               in_valid;
  logic signed [63:0] data_in;
  logic               out_valid;
  logic               out_ready;
  logic signed [15:0] data_out;
  logic               sat_flag;
  logic               ovf_flag;
  logic               flag_clear;
`ifdef FIR_REQUANT_SAT_CNT_EN
  logic [15:0]        sat_count;
`endif

  int n_checks;
  int n_pass;

  fir_out_requant dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .data_in    (data_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .data_out   (data_out),
    .sat_flag   (sat_flag),
    .ovf_flag   (ovf_flag),
    .flag_clear (flag_clear)
`ifdef FIR_REQUANT_SAT_CNT_EN
    ,
    .sat_count  (sat_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic signed [63:0] din;
    logic signed [15:0] dout;
    logic               sat;
  } vec_t;

  vec_t vecs [13];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic send(input logic signed [63:0] v);
    in_valid = 1'b1;
    data_in  = v;
    step();
    in_valid = 1'b0;
    data_in  = '0;
  endtask

  initial begin
    n_checks   = 0;
    n_pass     = 0;
    reset_n    = 1'b0;
    in_valid   = 1'b0;
    data_in    = '0;
    out_ready  = 1'b0;
    flag_clear = 1'b0;

    vecs[0]  = '{64'sd1 <<< 30, 16'sd1, 1'b0};
    vecs[1]  = '{-(64'sd1 <<< 30), 16'sd0, 1'b0};
    vecs[2]  = '{64'sd3 <<< 30, 16'sd2, 1'b0};
    vecs[3]  = '{64'sd1 <<< 47, 16'sd32767, 1'b1};
    vecs[4]  = '{-(64'sd1 <<< 47), -16'sd32768, 1'b1};
    vecs[5]  = '{64'sd32767 <<< 31, 16'sd32767, 1'b0};
    vecs[6]  = '{64'sd32768 <<< 31, 16'sd32767, 1'b1};
    vecs[7]  = '{-(64'sd32768 <<< 31), -16'sd32768, 1'b0};
    vecs[8]  = '{-(64'sd32768 <<< 31) - (64'sd1 <<< 30) - 64'sd1, -16'sd32768, 1'b1};
    vecs[9]  = '{-(64'sd1 <<< 30) - 64'sd1, -16'sd1, 1'b0};
    vecs[10] = '{64'sh7FFF_FFFF_FFFF_FFFF, 16'sd32767, 1'b1};
    vecs[11] = '{64'sh8000_0000_0000_0000, -16'sd32768, 1'b1};
    vecs[12] = '{(64'sd5 <<< 31) + (64'sd1 <<< 30) - 64'sd1, 16'sd5, 1'b0};

    step();
    step();
    chk("reset_out_valid", longint'(out_valid), 0);
    chk("reset_data_out", longint'(data_out), 0);
    chk("reset_sat_flag", longint'(sat_flag), 0);
    chk("reset_ovf_flag", longint'(ovf_flag), 0);
    reset_n = 1'b1;
    step();

    // Single samples through the pipeline: visible three cycles after presentation.
    out_ready = 1'b1;
    for (int i = 0; i < 13; i++) begin
      send(vecs[i].din);
      step();
      step();
      $display("vec %0d din=%0d data_out=%0d sat=%0d", i, vecs[i].din, data_out, sat_flag);
      chk($sformatf("vec%0d_valid", i), longint'(out_valid), 1);
      chk($sformatf("vec%0d_data", i), longint'(data_out), longint'(vecs[i].dout));
      chk($sformatf("vec%0d_sat", i), longint'(sat_flag), longint'(vecs[i].sat));
      flag_clear = 1'b1;
      step();
      flag_clear = 1'b0;
      chk($sformatf("vec%0d_popped", i), longint'(out_valid), 0);
      chk($sformatf("vec%0d_hold", i), longint'(data_out), longint'(vecs[i].dout));
      chk($sformatf("vec%0d_clr", i), longint'(sat_flag), 0);
    end

    // Stalled consumer: four buffered, two dropped.
    out_ready = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      send(64'(i) <<< 31);
    end
    step();
    step();
    step();
    $display("stall: out_valid=%0d data_out=%0d ovf=%0d", out_valid, data_out, ovf_flag);
    chk("stall_valid", longint'(out_valid), 1);
    chk("stall_head", longint'(data_out), 1);
    chk("stall_ovf", longint'(ovf_flag), 1);
    step();
    chk("stall_hold", longint'(data_out), 1);
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      $display("drain %0d data_out=%0d", i, data_out);
      chk($sformatf("drain%0d_valid", i), longint'(out_valid), 1);
      chk($sformatf("drain%0d_data", i), longint'(data_out), longint'(i));
      step();
    end
    chk("drain_empty", longint'(out_valid), 0);
    chk("drain_hold", longint'(data_out), 4);
    out_ready = 1'b0;

    flag_clear = 1'b1;
    step();
    flag_clear = 1'b0;
    chk("ovf_clear", longint'(ovf_flag), 0);

    // Full FIFO with simultaneous pop and push: nothing dropped.
    for (int i = 10; i <= 14; i++) begin
      send(64'(i) <<< 31);
    end
    step();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    $display("full_pop_push: data_out=%0d ovf=%0d", data_out, ovf_flag);
    chk("fpp_valid", longint'(out_valid), 1);
    chk("fpp_head", longint'(data_out), 11);
    chk("fpp_ovf", longint'(ovf_flag), 0);
    out_ready = 1'b1;
    for (int i = 11; i <= 14; i++) begin
      chk($sformatf("fpp_data%0d", i), longint'(data_out), longint'(i));
      step();
    end
    chk("fpp_empty", longint'(out_valid), 0);
    chk("fpp_ovf_after", longint'(ovf_flag), 0);

`ifdef FIR_REQUANT_SAT_CNT_EN
    for (int i = 0; i < 3; i++) begin
      send(64'sd1 <<< 47);
    end
    step();
    step();
    step();
    $display("sat_count=%0d", sat_count);
    chk("sat_count_3", longint'(sat_count), 3);
    flag_clear = 1'b1;
    step();
    flag_clear = 1'b0;
    chk("sat_count_clr", longint'(sat_count), 0);
`endif

    // Asynchronous reset with three entries buffered.
    out_ready = 1'b0;
    send(64'sd1 <<< 47);
    send(64'sd7 <<< 31);
    send(64'sd8 <<< 31);
    step();
    step();
    step();
    chk("pre_rst_valid", longint'(out_valid), 1);
    chk("pre_rst_sat", longint'(sat_flag), 1);
    #1;
    reset_n = 1'b0;
    #1;
    $display("mid reset: out_valid=%0d data_out=%0d sat=%0d ovf=%0d",
             out_valid, data_out, sat_flag, ovf_flag);
    chk("rst_valid", longint'(out_valid), 0);
    chk("rst_data", longint'(data_out), 0);
    chk("rst_sat", longint'(sat_flag), 0);
    chk("rst_ovf", longint'(ovf_flag), 0);
    step();
    reset_n = 1'b1;
    step();
    step();
    step();
    chk("post_rst_empty", longint'(out_valid), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
